// File: rtl/cm_arbiter_sched_pkg.sv
// cm_arbiter_sched_pkg: shared arbitration algorithm and FSM state types
package cm_arbiter_sched_pkg;
  typedef enum logic [1:0] {ARB_MIN, ARB_MAX, ARB_RR, ARB_WRR} t_arb_algo;
  typedef enum logic {ARB_IDLE, ARB_BUSY} t_arb_state;
endpackage

// File: rtl/cm_arbiter_sched_rr_pick.sv
// cm_arbiter_sched_rr_pick: first set mask bit at or after ptr, wrapping, as one-hot and index
module cm_arbiter_sched_rr_pick #(
  parameter int CH_CNT = 2,
  localparam int IDX_W = $clog2(CH_CNT)
) (
  input  logic [CH_CNT-1:0] mask,
  input  logic [IDX_W-1:0]  ptr,
  output logic [CH_CNT-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);
  logic [CH_CNT-1:0] rot;
  logic [IDX_W:0]    off, pos;
  always_comb begin
    rot = CH_CNT'({mask, mask} >> ptr);
    off = '0;
    for (int i = CH_CNT - 1; i >= 0; i--) if (rot[i]) off = (IDX_W+1)'(i);
    pos = {1'b0, ptr} + off;
    pos = pos >= (IDX_W+1)'(CH_CNT) ? pos - (IDX_W+1)'(CH_CNT) : pos;
    idx = pos[IDX_W-1:0];
    any = |mask;
    gnt = any ? CH_CNT'(1) << idx : '0;
  end
endmodule

// File: rtl/cm_arbiter_sched.sv
// cm_arbiter_sched: registered lock-holding arbiter with MIN/MAX/RR/WRR winner selection
module cm_arbiter_sched
  import cm_arbiter_sched_pkg::*;
#(
  parameter int        CH_CNT      = 2,
  parameter int        WEIGHT_BITS = 8,
  parameter t_arb_algo ALGO        = ARB_RR,
  localparam int       IDX_W       = $clog2(CH_CNT)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [CH_CNT-1:0]                  i_req,
  input  logic [CH_CNT-1:0][WEIGHT_BITS-1:0] i_weight,
  input  logic                               i_done,
  output logic [CH_CNT-1:0]                  o_gnt,
  output logic [IDX_W-1:0]                   o_gnt_idx,
  output logic                               o_busy
);
  t_arb_state              state_q, state_d;
  logic [CH_CNT-1:0]       gnt_d, mask, pick_mask, pick_gnt;
  logic [IDX_W-1:0]        idx_d, ptr_q, ptr_d, eff_ptr, nxt_idx, pick_idx;
  logic [WEIGHT_BITS-1:0]  credit_q, credit_d, credit_dec, win_wt;
  logic                    busy, hold, keep, rel, any;

  assign busy       = state_q == ARB_BUSY;
  assign hold       = i_req[o_gnt_idx];
  assign credit_dec = credit_q - 1'b1;
  // a WRR burst continues while credit remains and the holder still wants the resource
  assign keep       = ALGO == ARB_WRR && busy && i_done && hold && credit_dec != '0;
  assign rel        = busy && (i_done || !hold) && !keep;
  assign nxt_idx    = o_gnt_idx == IDX_W'(CH_CNT - 1) ? '0 : o_gnt_idx + 1'b1;
  assign eff_ptr    = busy ? nxt_idx : ptr_q;
  assign mask       = i_req & ~o_gnt;
  assign win_wt     = i_weight[pick_idx] == '0 ? WEIGHT_BITS'(1) : i_weight[pick_idx];
  assign o_busy     = |o_gnt;

  generate
    case (ALGO)
      ARB_MIN, ARB_MAX: begin : g_wt
        logic [WEIGHT_BITS-1:0] best;
        logic                   seen;
        always_comb begin
          best      = '0;
          seen      = 1'b0;
          pick_mask = '0;
          for (int i = 0; i < CH_CNT; i++)
            if (mask[i] && (!seen || (ALGO == ARB_MIN ? i_weight[i] < best : i_weight[i] > best))) begin
              best = i_weight[i];
              seen = 1'b1;
            end
          for (int i = 0; i < CH_CNT; i++) pick_mask[i] = mask[i] && i_weight[i] == best;
        end
      end
      default: begin : g_rr
        assign pick_mask = mask;
      end
    endcase
  endgenerate

  cm_arbiter_sched_rr_pick #(.CH_CNT(CH_CNT)) u_pick (
    .mask(pick_mask),
    .ptr (eff_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (any)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = o_gnt;
    idx_d    = o_gnt_idx;
    ptr_d    = rel ? nxt_idx : ptr_q;
    credit_d = keep ? credit_dec : credit_q;
    if (!busy || rel) begin
      state_d  = any ? ARB_BUSY : ARB_IDLE;
      gnt_d    = pick_gnt;
      idx_d    = any ? pick_idx : '0;
      credit_d = any ? win_wt : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ARB_IDLE;
      o_gnt     <= '0;
      o_gnt_idx <= '0;
      ptr_q     <= '0;
      credit_q  <= '0;
    end else begin
      state_q   <= state_d;
      o_gnt     <= gnt_d;
      o_gnt_idx <= idx_d;
      ptr_q     <= ptr_d;
      credit_q  <= credit_d;
    end
  end
endmodule
